apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_arb_pkg.sv | 21 ++
 rtl/apb_rr_pick.sv | 20 ++
 rtl/apb_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_apb_req_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB arbiter.
// Holds the FSM state encoding, the direction constants and the bus widths.
// No logic lives here.
package apb_arb_pkg;

    localparam int N_REQ  = 2;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/apb_rr_pick.sv
// Two-way round-robin picker: valids plus last-granted pointer to a one-hot grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module apb_rr_pick (
    input  logic [1:0] valid,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Arbitrates two requesters onto one APB master, one transfer in flight at a time.
// Latency: accept at N, transfer from N+1; xfer_done at D gives rsp_valid at D+2.
// Backpressure: req_ready only in IDLE; requests are never queued.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ-1:0]       req_rw,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    output logic                   transfer,
    output logic                   READ_WRITE,
    output logic [ADDR_W-1:0]      apb_write_paddr,
    output logic [ADDR_W-1:0]      apb_read_paddr,
    output logic [DATA_W-1:0]      apb_write_data,
    input  logic                   xfer_done,
    input  logic [DATA_W-1:0]      apb_read_data_out,
    input  logic                   PSLVERR
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    ready_int;
    logic                sel;

    apb_rr_pick u_pick (
        .valid (req_valid),
        .last  (last_q),
        .grant (grant)
    );

    assign sel = grant[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        owner_d   = owner_q;
        last_d    = last_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        ready_int = '0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    ready_int = grant;
                    owner_d   = sel;
                    last_d    = sel;
                    rw_d      = req_rw[sel];
                    addr_d    = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
                    wdata_d   = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
                    cnt_d     = CNT_W'(1);
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A completion on the last allowed cycle still counts as success.
                if (xfer_done) begin
                    cnt_d   = '0;
                    state_d = ST_CAPT;
                end else if (cnt_q == TMO) begin
                    cnt_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPT: begin
                rdata_d = (rw_q == RD) ? apb_read_data_out : '0;
                err_d   = PSLVERR;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The acceptance path is combinational, so mask it while reset is held.
    assign req_ready       = PRESETn ? ready_int : '0;
    assign rsp_valid       = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata       = rdata_q;
    assign rsp_err         = err_q;
    assign transfer        = (state_q == ST_BUSY);
    assign READ_WRITE      = rw_q;
    assign apb_write_paddr = addr_q;
    assign apb_read_paddr  = addr_q;
    assign apb_write_data  = wdata_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with hand-computed expectations.
module tb_apb_req_arbiter;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  req_valid;
    logic [1:0]  req_rw;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        transfer;
    logic        READ_WRITE;
    logic [8:0]  apb_write_paddr;
    logic [8:0]  apb_read_paddr;
    logic [7:0]  apb_write_data;
    logic        xfer_done;
    logic [7:0]  apb_read_data_out;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;
    int rsp0_cnt = 0;
    int rsp1_cnt = 0;

    apb_req_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .PCLK              (PCLK),
        .PRESETn           (PRESETn),
        .req_valid         (req_valid),
        .req_rw            (req_rw),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .transfer          (transfer),
        .READ_WRITE        (READ_WRITE),
        .apb_write_paddr   (apb_write_paddr),
        .apb_read_paddr    (apb_read_paddr),
        .apb_write_data    (apb_write_data),
        .xfer_done         (xfer_done),
        .apb_read_data_out (apb_read_data_out),
        .PSLVERR           (PSLVERR)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    always @(negedge PCLK) begin
        if (rsp_valid[0]) rsp0_cnt++;
        if (rsp_valid[1]) rsp1_cnt++;
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    function automatic logic [40:0] all_outs;
        return {transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data,
                req_ready, rsp_valid, rsp_rdata, rsp_err};
    endfunction

    task automatic test_reset;
        PRESETn = 1'b0;
        req_valid = 2'b11; req_rw = 2'b11; req_addr = 18'h3FFFF; req_wdata = 16'hFFFF;
        xfer_done = 1'b0; apb_read_data_out = 8'h00; PSLVERR = 1'b0;
        #2;
        checks++;
        if (all_outs() !== 41'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        tick; tick;
        req_valid = 2'b00;
        PRESETn = 1'b1;
        #1;
        checks++;
        if (transfer !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL reset_release_idle: transfer=%b rsp_valid=%b expected 0/00", transfer, rsp_valid);
        end
    endtask

    task automatic test_write;
        int c0;
        c0 = rsp0_cnt;
        req_rw = 2'b00; req_addr = 18'h00005; req_wdata = 16'h00A5; req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL wr_ready: got %b expected 01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        #1;
        checks++;
        if ({transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data}
            !== {1'b1, 1'b0, 9'h005, 9'h005, 8'hA5}) begin
            errors++; $display("FAIL wr_busy_bus: got t=%b rw=%b wa=%h ra=%h wd=%h expected 1 0 005 005 a5",
                               transfer, READ_WRITE, apb_write_paddr, apb_read_paddr, apb_write_data);
        end
        tick;
        #1;
        checks++;
        if (transfer !== 1'b1 || apb_write_data !== 8'hA5) begin
            errors++; $display("FAIL wr_busy_stable: got t=%b wd=%h expected 1 a5", transfer, apb_write_data);
        end
        tick;
        xfer_done = 1'b1;
        tick;
        xfer_done = 1'b0;
        #1;
        checks++;
        if (transfer !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL wr_capt: got t=%b rsp_valid=%b expected 0 00", transfer, rsp_valid);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL wr_resp: got rsp_valid=%b err=%b expected 01 0", rsp_valid, rsp_err);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || (rsp0_cnt - c0) !== 1) begin
            errors++; $display("FAIL wr_one_pulse: got rsp_valid=%b pulses=%0d expected 00 1", rsp_valid, rsp0_cnt - c0);
        end
    endtask

    task automatic test_read;
        int c1;
        c1 = rsp1_cnt;
        req_rw = 2'b10; req_addr = {9'h105, 9'h000}; req_wdata = 16'h0000; req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL rd_ready: got %b expected 10", req_ready);
        end
        tick;
        req_valid = 2'b00;
        #1;
        checks++;
        if (READ_WRITE !== 1'b1 || apb_read_paddr !== 9'h105 || transfer !== 1'b1) begin
            errors++; $display("FAIL rd_busy_bus: got rw=%b ra=%h t=%b expected 1 105 1", READ_WRITE, apb_read_paddr, transfer);
        end
        xfer_done = 1'b1; apb_read_data_out = 8'h3C;
        tick;
        xfer_done = 1'b0;
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 8'h3C || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rd_resp: got v=%b d=%h e=%b expected 10 3c 0", rsp_valid, rsp_rdata, rsp_err);
        end
        tick;
        #1;
        checks++;
        if ((rsp1_cnt - c1) !== 1) begin
            errors++; $display("FAIL rd_one_pulse: got %0d expected 1", rsp1_cnt - c1);
        end
        apb_read_data_out = 8'h00;
    endtask

    task automatic test_timeout;
        int bad;
        bad = 0;
        req_rw = 2'b00; req_addr = 18'h00020; req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL tmo_ready: got %b expected 01", req_ready);
        end
        tick;
        req_valid = 2'b00;
        for (int k = 2; k <= 16; k++) begin
            tick;
            if (transfer !== 1'b1 || rsp_valid !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL tmo_busy_hold: got %0d bad cycles expected 0", bad);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || transfer !== 1'b0) begin
            errors++; $display("FAIL tmo_resp: got v=%b e=%b d=%h t=%b expected 01 1 00 0",
                               rsp_valid, rsp_err, rsp_rdata, transfer);
        end
        xfer_done = 1'b1;
        tick; tick;
        #1;
        checks++;
        if (transfer !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL stray_done: got t=%b v=%b expected 0 00", transfer, rsp_valid);
        end
        xfer_done = 1'b0;
    endtask

    task automatic test_done_at_limit;
        req_rw = 2'b10; req_addr = {9'h1FF, 9'h000}; req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL lim_ready: got %b expected 10", req_ready);
        end
        tick;
        req_valid = 2'b00;
        for (int k = 2; k <= 16; k++) begin
            tick;
            if (k == 16) begin
                xfer_done = 1'b1; apb_read_data_out = 8'h77;
            end
        end
        tick;
        xfer_done = 1'b0;
        #1;
        checks++;
        if (transfer !== 1'b0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL lim_capt: got t=%b v=%b expected 0 00", transfer, rsp_valid);
        end
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 8'h77) begin
            errors++; $display("FAIL lim_resp: got v=%b e=%b d=%h expected 10 0 77", rsp_valid, rsp_err, rsp_rdata);
        end
        tick;
        apb_read_data_out = 8'h00;
    endtask

    task automatic test_pslverr;
        req_rw = 2'b01; req_addr = 18'h00010; req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        xfer_done = 1'b1; PSLVERR = 1'b1; apb_read_data_out = 8'h55;
        tick;
        xfer_done = 1'b0;
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 8'h55) begin
            errors++; $display("FAIL slverr_resp: got v=%b e=%b d=%h expected 01 1 55", rsp_valid, rsp_err, rsp_rdata);
        end
        PSLVERR = 1'b0; apb_read_data_out = 8'h00;
        tick;
    endtask

    task automatic test_round_robin;
        logic [1:0] exp_g [4];
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        PRESETn = 1'b0;
        tick; tick;
        PRESETn = 1'b1;
        req_rw = 2'b11; req_addr = {9'h111, 9'h022}; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (req_ready !== exp_g[i]) begin
                errors++; $display("FAIL rr_grant%0d: got %b expected %b", i, req_ready, exp_g[i]);
            end
            tick;
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                errors++; $display("FAIL rr_busy_ignore%0d: got %b expected 00", i, req_ready);
            end
            xfer_done = 1'b1; apb_read_data_out = 8'h99;
            tick;
            xfer_done = 1'b0;
            tick;
            #1;
            checks++;
            if (rsp_valid !== exp_g[i]) begin
                errors++; $display("FAIL rr_resp%0d: got %b expected %b", i, rsp_valid, exp_g[i]);
            end
            tick;
        end
        req_valid = 2'b00;
        apb_read_data_out = 8'h00;
    endtask

    task automatic test_reset_mid;
        int c0, c1;
        req_rw = 2'b00; req_addr = {9'h0AB, 9'h000}; req_wdata = 16'hCC00; req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++; $display("FAIL rst_mid_ready: got %b expected 10", req_ready);
        end
        tick;
        req_valid = 2'b11;
        #1;
        checks++;
        if (transfer !== 1'b1 || apb_write_data !== 8'hCC || apb_write_paddr !== 9'h0AB) begin
            errors++; $display("FAIL rst_mid_busy: got t=%b wd=%h wa=%h expected 1 cc 0ab", transfer, apb_write_data, apb_write_paddr);
        end
        c0 = rsp0_cnt; c1 = rsp1_cnt;
        PRESETn = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 41'd0) begin
            errors++; $display("FAIL rst_mid_outputs: got %h expected 0", all_outs());
        end
        xfer_done = 1'b1;
        tick; tick; tick;
        xfer_done = 1'b0;
        PRESETn = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01 || rsp0_cnt != c0 || rsp1_cnt != c1) begin
            errors++; $display("FAIL rst_mid_after: got ready=%b pulses=%0d/%0d expected 01 0/0",
                               req_ready, rsp0_cnt - c0, rsp1_cnt - c1);
        end
        tick;
        req_valid = 2'b00;
        xfer_done = 1'b1;
        tick;
        xfer_done = 1'b0;
        tick;
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_resume: got v=%b e=%b expected 01 0", rsp_valid, rsp_err);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_done_at_limit;
        test_pslverr;
        test_round_robin;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
